// File: rtl/shop_cmd_tx.sv
// Shop command transmitter: frames a key word plus up to two
// argument words as one-cycle beats with a configurable idle gap.
module shop_cmd_tx #(
  parameter int I_U_NUM_BITS = 4,
  parameter int O_A_NUM_BITS = 24,
  parameter int MAX_USERS    = 5,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [2:0]              i_op,
  input  logic [I_U_NUM_BITS-1:0] i_uid,
  input  logic [1:0]              i_nargs,
  input  logic [O_A_NUM_BITS-1:0] i_arg0,
  input  logic [O_A_NUM_BITS-1:0] i_arg1,
  output logic                    o_rdy,
  output logic [I_U_NUM_BITS-1:0] o_u,
  output logic [O_A_NUM_BITS-1:0] o_a,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int CW =
    (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES);
  localparam logic [I_U_NUM_BITS:0] MAX_U =
    (I_U_NUM_BITS + 1)'(MAX_USERS);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_GAP, S_ARG, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [I_U_NUM_BITS-1:0] uid_q;
  logic [1:0]              nargs_q;
  logic [O_A_NUM_BITS-1:0] arg0_q;
  logic [O_A_NUM_BITS-1:0] arg1_q;
  logic                    idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    rdy_d;
  logic [I_U_NUM_BITS-1:0] u_d;
  logic [O_A_NUM_BITS-1:0] a_d;
  logic                    busy_d;
  logic                    done_d;
  logic                    err_d;

  logic take;
  logic bad;

  function automatic logic [O_A_NUM_BITS-1:0] key_word(
    input logic [2:0] op
  );
    logic [23:0] k;
    k = 24'h0;
    case (op)
      3'd0:    k = 24'h4C474F;
      3'd1:    k = 24'h4C4749;
      3'd2:    k = 24'h414455;
      3'd3:    k = 24'h444C55;
      3'd4:    k = 24'h414449;
      3'd5:    k = 24'h444C49;
      3'd6:    k = 24'h425559;
      default: k = 24'h0;
    endcase
    return O_A_NUM_BITS'(k);
  endfunction

  assign take = (state_q == S_IDLE) && i_start;
  assign bad  = (i_op == 3'd7) || (i_nargs == 2'd3) ||
                ({1'b0, i_uid} >= MAX_U);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 1'b0;
      uid_q   <= '0;
      nargs_q <= '0;
      arg0_q  <= '0;
      arg1_q  <= '0;
      o_rdy   <= 1'b0;
      o_u     <= '0;
      o_a     <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (take) begin
        uid_q   <= i_uid;
        nargs_q <= i_nargs;
        arg0_q  <= i_arg0;
        arg1_q  <= i_arg1;
      end
      o_rdy  <= rdy_d;
      o_u    <= u_d;
      o_a    <= a_d;
      o_busy <= busy_d;
      o_done <= done_d;
      o_err  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = bad ? S_ERR : S_KEY;
          idx_d   = 1'b0;
        end
      end
      S_KEY: begin
        if (nargs_q == 2'd0) begin
          state_d = S_DONE;
        end else if (GAP_CYCLES == 0) begin
          state_d = S_ARG;
        end else begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end
      end
      S_GAP: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_ARG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ARG: begin
        // nargs is 1 or 2 here; idx marks the second argument
        if ((nargs_q == 2'd1) || idx_q) begin
          state_d = S_DONE;
        end else begin
          idx_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = S_ARG;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land registered.
  always_comb begin
    rdy_d  = 1'b0;
    u_d    = '0;
    a_d    = '0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    unique case (state_d)
      S_KEY: begin
        rdy_d = 1'b1;
        u_d   = i_uid;
        a_d   = key_word(i_op);
      end
      S_ARG: begin
        rdy_d = 1'b1;
        u_d   = uid_q;
        a_d   = idx_d ? arg1_q : arg0_q;
      end
      default: begin
        rdy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shop_cmd_tx.sv
// Scoreboard bench for shop_cmd_tx: one instance with a one-cycle
// gap and one with no gap, driven from shared directed vectors.
module tb_shop_cmd_tx;

  localparam logic [23:0] LGO = 24'h4C474F;
  localparam logic [23:0] LGI = 24'h4C4749;
  localparam logic [23:0] ADU = 24'h414455;
  localparam logic [23:0] ADI = 24'h414449;
  localparam logic [23:0] DLI = 24'h444C49;
  localparam logic [23:0] BUY = 24'h425559;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  u;
    logic [23:0] a;
  } ev_t;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        start1, start0;
  logic [2:0]  i_op;
  logic [3:0]  i_uid;
  logic [1:0]  i_nargs;
  logic [23:0] i_arg0, i_arg1;

  logic        rdy1, busy1, done1, err1;
  logic [3:0]  u1;
  logic [23:0] a1;
  logic        rdy0, busy0, done0, err0;
  logic [3:0]  u0;
  logic [23:0] a0;

  ev_t q1[$];
  ev_t q0[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  int done_c1, done_c0, err_c1, err_c0, busy_n1, busy_n0;
  logic [15:0] m1, m0;

  always #5 clk = ~clk;

  shop_cmd_tx #(.GAP_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_start(start1),
    .i_op(i_op), .i_uid(i_uid), .i_nargs(i_nargs),
    .i_arg0(i_arg0), .i_arg1(i_arg1),
    .o_rdy(rdy1), .o_u(u1), .o_a(a1),
    .o_busy(busy1), .o_done(done1), .o_err(err1)
  );

  shop_cmd_tx #(.GAP_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(i_reset), .i_start(start0),
    .i_op(i_op), .i_uid(i_uid), .i_nargs(i_nargs),
    .i_arg0(i_arg0), .i_arg1(i_arg1),
    .o_rdy(rdy0), .o_u(u0), .o_a(a0),
    .o_busy(busy0), .o_done(done0), .o_err(err0)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [1:0] k,
                      input logic [3:0] u, input logic [23:0] a);
    ev_t e;
    e.kind = k;
    e.u    = u;
    e.a    = a;
    if (d == 1) q1.push_back(e);
    else        q0.push_back(e);
  endtask

  task automatic push_both(input logic [1:0] k, input logic [3:0] u,
                           input logic [23:0] a);
    push(1, k, u, a);
    push(0, k, u, a);
  endtask

  task automatic mon(input int d, input logic rdy, input logic done,
                     input logic err, input logic [3:0] u,
                     input logic [23:0] a);
    ev_t got, exp;
    int  n;
    bit  empty;
    if (!rdy) chk($sformatf("idle_zero%0d", d), {36'h0, u, a}, 64'h0);
    if (rdy || done || err) begin
      n = int'(rdy) + int'(done) + int'(err);
      chk($sformatf("onehot%0d", d), 64'(n), 64'd1);
      got.kind = rdy ? 2'd0 : (done ? 2'd1 : 2'd2);
      got.u    = u;
      got.a    = a;
      empty = (d == 1) ? (q1.size() == 0) : (q0.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL unexpected%0d: got %0h expected none", d, got);
      end else begin
        exp = (d == 1) ? q1.pop_front() : q0.pop_front();
        chk($sformatf("event%0d", d), 64'(got), 64'(exp));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(1, rdy1, done1, err1, u1, a1);
      mon(0, rdy0, done0, err0, u0, a0);
    end
  end

  task automatic run(input logic [2:0] op, input logic [3:0] uid,
                     input logic [1:0] na, input logic [23:0] x0,
                     input logic [23:0] x1, input int p1a,
                     input int p1b, input int p0a, input int p0b,
                     input int rc);
    @(negedge clk);
    i_reset = 1'b0;
    i_op    = op;
    i_uid   = uid;
    i_nargs = na;
    i_arg0  = x0;
    i_arg1  = x1;
    start1  = 1'b1;
    start0  = 1'b1;
    done_c1 = 0; done_c0 = 0;
    err_c1  = 0; err_c0  = 0;
    busy_n1 = 0; busy_n0 = 0;
    m1 = '0; m0 = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done1) done_c1 = c;
      if (done0) done_c0 = c;
      if (err1)  err_c1  = c;
      if (err0)  err_c0  = c;
      if (busy1) busy_n1++;
      if (busy0) busy_n0++;
      if (rdy1)  m1[c] = 1'b1;
      if (rdy0)  m0[c] = 1'b1;
      if (rc != 0 && c == rc + 1) begin
        chk("rst_zero1", {rdy1, u1, a1, busy1, done1, err1}, 64'h0);
        chk("rst_zero0", {rdy0, u0, a0, busy0, done0, err0}, 64'h0);
      end
      start1  = (c == p1a) || (c == p1b);
      start0  = (c == p0a) || (c == p0b);
      if (start1 || start0) begin
        i_op    = 3'd4;
        i_uid   = 4'd1;
        i_nargs = 2'd0;
        i_arg0  = 24'hDEAD00;
        i_arg1  = 24'hBEEF00;
      end
      i_reset = (rc != 0) && (c == rc);
    end
  endtask

  task automatic expect_run(input string t, input int dn1,
                            input int dn0, input int bz1,
                            input int bz0, input int er,
                            input logic [15:0] mk1,
                            input logic [15:0] mk0);
    chk({t, "_done1"}, 64'(done_c1), 64'(dn1));
    chk({t, "_done0"}, 64'(done_c0), 64'(dn0));
    chk({t, "_busy1"}, 64'(busy_n1), 64'(bz1));
    chk({t, "_busy0"}, 64'(busy_n0), 64'(bz0));
    chk({t, "_err1"},  64'(err_c1),  64'(er));
    chk({t, "_err0"},  64'(err_c0),  64'(er));
    chk({t, "_rdy1"},  64'(m1),      64'(mk1));
    chk({t, "_rdy0"},  64'(m0),      64'(mk0));
  endtask

  initial begin
    i_reset = 1'b1;
    start1  = 1'b1;
    start0  = 1'b1;
    i_op    = 3'd1;
    i_uid   = 4'd0;
    i_nargs = 2'd0;
    i_arg0  = '0;
    i_arg1  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset1", {rdy1, u1, a1, busy1, done1, err1}, 64'h0);
    chk("reset0", {rdy0, u0, a0, busy0, done0, err0}, 64'h0);
    start1 = 1'b0;
    start0 = 1'b0;
    mon_en = 1'b1;

    // Login uid0 "Adm"
    push_both(2'd0, 4'd0, LGI);
    push_both(2'd0, 4'd0, 24'h41646D);
    push_both(2'd1, 4'd0, 24'h0);
    run(3'd1, 4'd0, 2'd1, 24'h41646D, 24'h0, 0, 0, 0, 0, 0);
    expect_run("login", 4, 3, 4, 3, 0, 16'b1010, 16'b0110);

    // Buy uid2 two args, start pulsed in GAP/ARG and DONE
    push_both(2'd0, 4'd2, BUY);
    push_both(2'd0, 4'd2, 24'h123456);
    push_both(2'd0, 4'd2, 24'hABCDEF);
    push_both(2'd1, 4'd0, 24'h0);
    run(3'd6, 4'd2, 2'd2, 24'h123456, 24'hABCDEF, 2, 6, 2, 4, 0);
    expect_run("buy", 6, 4, 6, 4, 0, 16'b101010, 16'b1110);

    // rejected requests
    push_both(2'd2, 4'd0, 24'h0);
    run(3'd2, 4'd5, 2'd1, 24'h112233, 24'h0, 0, 0, 0, 0, 0);
    expect_run("bad_uid", 0, 0, 1, 1, 1, 16'h0, 16'h0);
    push_both(2'd2, 4'd0, 24'h0);
    run(3'd7, 4'd1, 2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0);
    expect_run("bad_op", 0, 0, 1, 1, 1, 16'h0, 16'h0);
    push_both(2'd2, 4'd0, 24'h0);
    run(3'd5, 4'd1, 2'd3, 24'h0, 24'h0, 0, 0, 0, 0, 0);
    expect_run("bad_nargs", 0, 0, 1, 1, 1, 16'h0, 16'h0);

    // highest valid uid, zero args
    push_both(2'd0, 4'd4, DLI);
    push_both(2'd1, 4'd0, 24'h0);
    run(3'd5, 4'd4, 2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0);
    expect_run("max_uid", 2, 2, 2, 2, 0, 16'b10, 16'b10);

    // reset in the cycle after the key beat
    push(1, 2'd0, 4'd3, ADI);
    push(0, 2'd0, 4'd3, ADI);
    push(0, 2'd0, 4'd3, 24'h0A0B0C);
    run(3'd4, 4'd3, 2'd2, 24'h0A0B0C, 24'h0D0E0F, 0, 0, 0, 0, 2);
    expect_run("reset_mid", 0, 0, 2, 2, 0, 16'b10, 16'b110);

    // Logout taken on first edge after reset drops
    @(negedge clk);
    i_reset = 1'b1;
    push_both(2'd0, 4'd1, LGO);
    push_both(2'd1, 4'd0, 24'h0);
    run(3'd0, 4'd1, 2'd0, 24'h0, 24'h0, 0, 0, 0, 0, 0);
    expect_run("logout", 2, 2, 2, 2, 0, 16'b10, 16'b10);

    // AddUsr uid1 one arg, clean frame
    push_both(2'd0, 4'd1, ADU);
    push_both(2'd0, 4'd1, 24'h426F62);
    push_both(2'd1, 4'd0, 24'h0);
    run(3'd2, 4'd1, 2'd1, 24'h426F62, 24'h0, 0, 0, 0, 0, 0);
    expect_run("addusr", 4, 3, 4, 3, 0, 16'b1010, 16'b0110);

    @(negedge clk);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q0_empty", 64'(q0.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
